// File: rtl/pipo_share_ctrl_pkg.sv
// Shared constants and helpers for the round-robin PIPO sharing controller.
package pipo_share_pkg;

  localparam int N_DEFAULT = 4;
  localparam int WIDTH_DEFAULT = 8;
  localparam logic [15:0] BUSY_MAX = 16'hFFFF;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int src_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipo_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after rr_ptr, wrapping modulo N.
module rr_arbiter
  import pipo_share_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int SRC_W = src_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] rr_ptr,
  input  logic             enable,
  output logic [N-1:0]     gnt,
  output logic [SRC_W-1:0] gnt_idx
);

  logic             found_s;
  logic             hit_s;
  logic [SRC_W-1:0] idx_s;

  // Scan from the pointer position; only the first hit is granted.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    idx_s   = '0;
    for (int i = 0; i < N; i++) begin
      idx_s      = SRC_W'((32'(rr_ptr) + 32'(i)) % 32'(N));
      hit_s      = enable && !found_s && req[idx_s];
      gnt[idx_s] = gnt[idx_s] | hit_s;
      gnt_idx    = hit_s ? idx_s : gnt_idx;
      found_s    = found_s | hit_s;
    end
  end

endmodule

// File: rtl/pipo_share_ctrl.sv
// Shares one PIPO holding register among N requesters with round-robin grant
// and a valid/ready output; the top owns all state.
module pipo_share_ctrl
  import pipo_share_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SRC_W = src_w(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] din,
  output logic [N-1:0]       gnt,
  output logic [WIDTH-1:0]   q,
  output logic               q_valid,
  input  logic               q_ready,
  output logic [SRC_W-1:0]   q_src,
  output logic [15:0]        busy_cnt
);

  logic [WIDTH-1:0] q_r;
  logic             q_valid_r;
  logic [SRC_W-1:0] q_src_r;
  logic [SRC_W-1:0] rr_ptr_r;
  logic [15:0]      busy_cnt_r;

  logic             slot_free_s;
  logic             load_s;
  logic [SRC_W-1:0] gnt_idx_s;
  logic [SRC_W-1:0] ptr_next_s;
  logic             stall_s;
  logic [WIDTH-1:0] words_s [N];

  // A slot opens when empty or when the current word drains this cycle.
  always_comb begin
    slot_free_s = !q_valid_r || q_ready;
    load_s      = slot_free_s && (req != '0);
    stall_s     = (req != '0) && (gnt == '0);
  end

  // Unpack the request words and compute the pointer that follows the winner.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      words_s[i] = din[i*WIDTH +: WIDTH];
    end
    if (gnt_idx_s == SRC_W'(N - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = gnt_idx_s + SRC_W'(1);
    end
  end

  // Gating with rst_n keeps gnt low for the whole time reset is asserted.
  rr_arbiter #(
    .N     (N),
    .SRC_W (SRC_W)
  ) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr_r),
    .enable  (load_s && rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx_s)
  );

  // Holding register, handshake state and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r       <= '0;
      q_valid_r <= 1'b0;
      q_src_r   <= '0;
      rr_ptr_r  <= '0;
    end else if (load_s) begin
      q_r       <= words_s[gnt_idx_s];
      q_valid_r <= 1'b1;
      q_src_r   <= gnt_idx_s;
      rr_ptr_r  <= ptr_next_s;
    end else if (q_valid_r && q_ready) begin
      q_valid_r <= 1'b0;
    end else begin
      q_valid_r <= q_valid_r;
    end
  end

  // Saturating count of cycles where somebody asked but nobody was granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt_r <= 16'd0;
    end else if (stall_s && (busy_cnt_r != BUSY_MAX)) begin
      busy_cnt_r <= busy_cnt_r + 16'd1;
    end else begin
      busy_cnt_r <= busy_cnt_r;
    end
  end

  assign q        = q_r;
  assign q_valid  = q_valid_r;
  assign q_src    = q_src_r;
  assign busy_cnt = busy_cnt_r;

endmodule

// File: doc/pipo_share_ctrl.md
Name: pipo_share_ctrl

Overview:
- Shares one WIDTH-bit parallel-in/parallel-out holding register among N requesters, using round-robin arbitration.
- Each requester presents a word plus a request. The controller grants one requester per load cycle and captures its word into the register.
- The captured word is presented downstream with a valid/ready handshake.
- Sits between several producer blocks and a single downstream consumer of PIPO-registered data.

Parameters:
- N, 4, number of requesters (2..16).
- WIDTH, 8, data width of each word and of the shared register.
- SRC_W, $clog2(N), width of the source-index field.

Ports:
- clk  input  1  system clock; all state updates on the posedge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request; bit i = requester i has a word on din slice i.
- din  input  N*WIDTH  packed request words; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  output  N  one-hot grant; combinational. Bit i high = din slice i is captured at this posedge.
- q  output  WIDTH  registered held word.
- q_valid  output  1  q holds an unconsumed word.
- q_ready  input  1  downstream accepts q this cycle.
- q_src  output  SRC_W  index of the requester whose word is in q.
- busy_cnt  output  16  count of cycles in which req was nonzero but gnt was zero. Saturates at 16'hFFFF.

Behaviour:
- Reset (rst_n low, asynchronous): q=0, q_valid=0, q_src=0, busy_cnt=0, round-robin pointer rr_ptr=0. gnt is 0 while rst_n is low.
- Slot free condition: slot_free = !q_valid || q_ready.
- Load condition: load = slot_free && (req != 0).
- Grant selection:
  - When load is true, gnt selects the first set req bit, scanning rr_ptr, rr_ptr+1, ... with wrap modulo N.
  - Otherwise gnt = 0.
  - gnt is purely combinational from req, rr_ptr, q_valid and q_ready.
- On posedge with load, requester k granted:
  - q <= din slice k; q_src <= k; q_valid <= 1.
  - rr_ptr <= (k+1) mod N; wraps from N-1 to 0.
- On posedge with q_valid && q_ready && !load: q_valid <= 0. q and q_src retain their values.
- Simultaneous drain and load (q_valid && q_ready && req != 0):
  - Old word is consumed and the new word is captured in the same edge.
  - Sustained throughput is 1 word/cycle.
- Otherwise q, q_valid, q_src and rr_ptr hold.
- Latency: grant to q_valid is 1 cycle.
- Hold rule: while q_valid && !q_ready, q and q_src remain stable and gnt = 0 (backpressure).
- Requester contract:
  - A requester must hold req and din until it sees its gnt bit.
  - Dropping req before grant is legal and simply withdraws the request.
- Fairness: a continuously asserted request is granted within N load cycles.
- busy_cnt:
  - Increments on each posedge where req != 0 && gnt == 0.
  - Holds at 16'hFFFF once reached.
- Reset asserted mid-operation: any held word is discarded immediately, and no grant is issued in the reset-release cycle unless load is true after release.
- States (implicit in q_valid):
  - EMPTY (q_valid=0) -> FULL on load.
  - FULL -> FULL on load while draining, or while stalled.
  - FULL -> EMPTY on drain without load.

Decomposition:
- Package pipo_share_pkg holds:
  - the default N and WIDTH constants;
  - a function src_w(n) returning $clog2(n), clamped to a minimum of 1;
  - the saturation constant BUSY_MAX = 16'hFFFF.
- Sub-module rr_arbiter (parameter N): combinational.
  - Inputs: req, rr_ptr, enable.
  - Outputs: one-hot gnt and the encoded grant index.
  - The top level owns all registers (q, q_valid, q_src, rr_ptr, busy_cnt).

Test Plan:
- Reset check: assert rst_n=0 mid-run with q_valid=1 and q=8'hA5 -> q=0, q_valid=0, q_src=0, busy_cnt=0 asynchronously, before the next clk edge.
- Single requester: req=4'b0100, din slice2=8'h3C, q_ready=1 -> gnt=4'b0100 in that cycle; next cycle q=8'h3C, q_src=2, q_valid=1. rr_ptr becomes 3.
- Round robin: req=4'b1111 held, with slices 8'h10, 8'h11, 8'h12, 8'h13, q_ready=1, rr_ptr=0 -> q sequence 10, 11, 12, 13, 10 on consecutive cycles. q_src sequence 0, 1, 2, 3, 0 (wrap).
- Backpressure:
  - Load 8'h55, then q_ready=0 for 3 cycles with req=4'b0001 -> q stays 8'h55, gnt=0, busy_cnt increments by 3.
  - Then q_ready=1 -> same-cycle drain+load; next cycle q = new word.
- Drain without load: q_valid=1, q_ready=1, req=0 -> next cycle q_valid=0 and q unchanged.
- Saturation: force continuous stall for 70000 cycles with req != 0 -> busy_cnt stops at 16'hFFFF and does not wrap to 0.
